// File: rtl/load_store_unit.sv
// RV32 memory-access stage: handshaked load/store FSM with byte lanes, load extension, DMEM ACK and bus timeout.
// Optional MISALIGN_TRAP_EN: misaligned requests trap without a bus cycle instead of being aligned down.
module load_store_unit #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  halt,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [2:0]            req_size,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  stall,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic [4:0]            resp_rd,
   output logic                  resp_err,
   output logic                  DMEM_REQ,
   output logic                  DMEM_READ_WRN,
   output logic [ADDR_WIDTH-1:0] DMEM_ADDRESS_BUS,
   output logic [3:0]            DMEM_BYTE_EN,
   output logic [31:0]           DMEM_DATA_OUT_BUS,
   input  logic [31:0]           DMEM_DATA_IN_BUS,
   input  logic                  DMEM_ACK
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [3:0]            be_r;
   logic [31:0]           wdata_r;
   logic                  read_wrn_r;
   logic [4:0]            rd_r;
   logic [2:0]            size_r;
   logic [1:0]            off_r;
   logic [CNT_WIDTH-1:0]  cnt_r;
   logic [31:0]           resp_rdata_r;
   logic [4:0]            resp_rd_r;
   logic                  resp_err_r;

   logic                  accept_s;
   logic                  misalign_s;
   logic                  trap_s;
   logic                  timeout_hit_s;
   logic [1:0]            eff_off_s;
   logic [3:0]            be_s;
   logic [31:0]           lane_wdata_s;
   logic [31:0]           lane_s;
   logic [31:0]           load_data_s;
   logic                  unused_addr_s;

   assign unused_addr_s = ^req_addr[31:ADDR_WIDTH];
   assign accept_s      = (state_r == ST_IDLE) && req_valid && !halt && !req_op[1];
   assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

   // Request decode: lane offset (aligned down), byte enables, replicated store data, misalignment
   always_comb begin
      eff_off_s    = req_addr[1:0];
      be_s         = 4'b1111;
      lane_wdata_s = req_wdata;
      misalign_s   = 1'b0;
      case (req_size)
         3'b001, 3'b010: begin
            eff_off_s    = {req_addr[1], 1'b0};
            be_s         = 4'b0011 << eff_off_s;
            lane_wdata_s = {2{req_wdata[15:0]}};
            misalign_s   = req_addr[0];
         end
         3'b011, 3'b100: begin
            eff_off_s    = req_addr[1:0];
            be_s         = 4'b0001 << eff_off_s;
            lane_wdata_s = {4{req_wdata[7:0]}};
            misalign_s   = 1'b0;
         end
         default: begin
            eff_off_s    = 2'b00;
            be_s         = 4'b1111;
            lane_wdata_s = req_wdata;
            misalign_s   = (req_addr[1:0] != 2'b00);
         end
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign trap_s = accept_s && misalign_s;
`else
   assign trap_s = 1'b0;
`endif

   // Load lane selection and zero/sign extension of the returned bus word
   always_comb begin
      lane_s = DMEM_DATA_IN_BUS >> {off_r, 3'b000};
      case (size_r)
         3'b001:  load_data_s = {16'h0000, lane_s[15:0]};
         3'b010:  load_data_s = {{16{lane_s[15]}}, lane_s[15:0]};
         3'b011:  load_data_s = {24'h00_0000, lane_s[7:0]};
         3'b100:  load_data_s = {{24{lane_s[7]}}, lane_s[7:0]};
         default: load_data_s = lane_s;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; halt only gates acceptance and the exit from RESP
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = trap_s ? ST_RESP : ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (DMEM_ACK || timeout_hit_s) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         ST_RESP: begin
            if (!halt) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Request capture, timeout counting and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r       <= {ADDR_WIDTH{1'b0}};
         be_r         <= 4'b0000;
         wdata_r      <= 32'h0000_0000;
         read_wrn_r   <= 1'b1;
         rd_r         <= 5'd0;
         size_r       <= 3'b000;
         off_r        <= 2'b00;
         cnt_r        <= {CNT_WIDTH{1'b0}};
         resp_rdata_r <= 32'h0000_0000;
         resp_rd_r    <= 5'd0;
         resp_err_r   <= 1'b0;
      end else if (accept_s) begin
         addr_r     <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
         be_r       <= be_s;
         wdata_r    <= lane_wdata_s;
         read_wrn_r <= ~req_op[0];
         rd_r       <= req_rd;
         size_r     <= req_size;
         off_r      <= eff_off_s;
         cnt_r      <= {CNT_WIDTH{1'b0}};
         if (trap_s) begin
            resp_rdata_r <= 32'h0000_0000;
            resp_rd_r    <= req_rd;
            resp_err_r   <= 1'b1;
         end
      end else if (state_r == ST_ACCESS) begin
         if (DMEM_ACK) begin
            resp_rdata_r <= read_wrn_r ? load_data_s : 32'h0000_0000;
            resp_rd_r    <= read_wrn_r ? rd_r : 5'd0;
            resp_err_r   <= 1'b0;
         end else if (timeout_hit_s) begin
            resp_rdata_r <= 32'h0000_0000;
            resp_rd_r    <= read_wrn_r ? rd_r : 5'd0;
            resp_err_r   <= 1'b1;
         end else begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
         end
      end
   end

   assign req_ready         = (state_r == ST_IDLE);
   assign stall             = (state_r != ST_IDLE);
   assign resp_valid        = (state_r == ST_RESP);
   assign resp_rdata        = resp_rdata_r;
   assign resp_rd           = resp_rd_r;
   assign resp_err          = resp_err_r;
   assign DMEM_REQ          = (state_r == ST_ACCESS);
   assign DMEM_READ_WRN     = read_wrn_r;
   assign DMEM_ADDRESS_BUS  = addr_r;
   assign DMEM_BYTE_EN      = be_r;
   assign DMEM_DATA_OUT_BUS = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops against an arithmetic reference model.
module tb_load_store_unit;

   localparam int AW  = 16;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rst, halt, req_valid, req_ready;
   logic [1:0]    req_op;
   logic [2:0]    req_size;
   logic [31:0]   req_addr, req_wdata;
   logic [4:0]    req_rd;
   logic          stall, resp_valid, resp_err;
   logic [31:0]   resp_rdata;
   logic [4:0]    resp_rd;
   logic          dmem_req, dmem_rwn, dmem_ack;
   logic [AW-1:0] dmem_addr;
   logic [3:0]    dmem_be;
   logic [31:0]   dmem_dout, dmem_din;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] last_addr, last_be, last_dout, last_rwn, last_rdata, last_rd, last_err, last_req;

   load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .halt(halt), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
      .DMEM_REQ(dmem_req), .DMEM_READ_WRN(dmem_rwn), .DMEM_ADDRESS_BUS(dmem_addr), .DMEM_BYTE_EN(dmem_be),
      .DMEM_DATA_OUT_BUS(dmem_dout), .DMEM_DATA_IN_BUS(dmem_din), .DMEM_ACK(dmem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int size_bytes(input logic [2:0] size);
      if (size == 3'd1 || size == 3'd2) return 2;
      if (size == 3'd3 || size == 3'd4) return 1;
      return 4;
   endfunction

   // Reference load value: pick the naturally aligned lane, then zero- or sign-extend arithmetically
   function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr,
                                              input logic [31:0] din);
      int nb, off;
      logic [31:0] v, bound;
      nb  = size_bytes(size);
      off = int'(addr[1:0]);
      off = off - (off % nb);
      v   = din >> (8 * off);
      if (nb == 4) return v;
      bound = 32'd1 << (8 * nb);
      v = v % bound;
      if ((size == 3'd2 || size == 3'd4) && v >= bound / 32'd2) v = v - bound;
      return v;
   endfunction

   function automatic logic [31:0] model_be(input logic [2:0] size, input logic [31:0] addr);
      int nb, off;
      nb  = size_bytes(size);
      off = int'(addr[1:0]);
      off = off - (off % nb);
      return ((32'd1 << nb) - 32'd1) << off;
   endfunction

   function automatic logic [31:0] model_dout(input logic [2:0] size, input logic [31:0] w);
      int nb;
      logic [31:0] pat, r;
      nb = size_bytes(size);
      if (nb == 4) return w;
      pat = w % (32'd1 << (8 * nb));
      r = 32'd0;
      for (int k = 0; k < 4 / nb; k++) r = r | (pat << (8 * nb * k));
      return r;
   endfunction

   // One complete transaction: present request, model the DMEM slave, check bus, response and halt stretching
   task automatic do_op(input logic [1:0] op, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] din,
                        input int lat, input int hold, input bit noise);
      bit is_load, is_trap, tmo;
      int n_acc;
      logic [31:0] e_rdata, e_rd;
      is_load = (op == 2'b00);
      is_trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      is_trap = (addr % size_bytes(size)) != 0;
`endif
      tmo   = !is_trap && (lat >= TMO);
      n_acc = is_trap ? 0 : (tmo ? TMO : lat + 1);
      halt = 1'b0; req_valid = 1'b1; req_op = op; req_size = size;
      req_addr = addr; req_wdata = wdata; req_rd = rd;
      check("ready_idle", {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      last_req = {31'd0, dmem_req};
      for (int i = 0; i < n_acc; i++) begin
         check("acc_req", {31'd0, dmem_req}, 32'd1);
         check("acc_stall", {31'd0, stall}, 32'd1);
         check("acc_addr", {16'd0, dmem_addr}, (addr % 32'h1_0000) & 32'hFFFF_FFFC);
         check("acc_be", {28'd0, dmem_be}, model_be(size, addr));
         check("acc_rwn", {31'd0, dmem_rwn}, {31'd0, is_load});
         if (!is_load) check("acc_dout", dmem_dout, model_dout(size, wdata));
         if (i == 0) begin
            last_addr = {16'd0, dmem_addr}; last_be = {28'd0, dmem_be};
            last_dout = dmem_dout; last_rwn = {31'd0, dmem_rwn};
         end
         if (noise) begin
            req_valid = 1'($urandom); req_op = 2'($urandom); req_addr = $urandom;
            req_size = 3'($urandom); halt = 1'($urandom);
         end
         dmem_din = $urandom;
         if (!tmo && i == lat) begin
            dmem_ack = 1'b1; dmem_din = din;
         end
         step();
         dmem_ack = 1'b0;
      end
      halt = 1'b0;
      e_rdata = (is_load && !tmo && !is_trap) ? model_load(size, addr, din) : 32'd0;
      e_rd    = (is_load || is_trap) ? {27'd0, rd} : 32'd0;
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("resp_err", {31'd0, resp_err}, {31'd0, (tmo || is_trap)});
      check("resp_rdata", resp_rdata, e_rdata);
      if (!tmo) check("resp_rd", {27'd0, resp_rd}, e_rd);
      last_rdata = resp_rdata; last_rd = {27'd0, resp_rd}; last_err = {31'd0, resp_err};
      for (int h = 0; h < hold; h++) begin
         halt = 1'b1;
         step();
         check("halt_resp_valid", {31'd0, resp_valid}, 32'd1);
         check("halt_rdata", resp_rdata, e_rdata);
      end
      halt = 1'b0;
      step();
      req_valid = 1'b0;
      check("post_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("post_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; halt = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_size = 3'b000;
      req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; dmem_ack = 1'b0; dmem_din = 32'd0;
      step();
      step();
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_rwn", {31'd0, dmem_rwn}, 32'd1);
      check("rst_be", {28'd0, dmem_be}, 32'd0);
      rst = 1'b0;
      step();

      do_op(2'b00, 3'b000, 32'h0000_0104, 32'd0, 5'd7, 32'hDEAD_BEEF, 0, 0, 1'b0);
      check("t1_addr", last_addr, 32'h0000_0104);
      check("t1_be", last_be, 32'h0000_000F);
      check("t1_rdata", last_rdata, 32'hDEAD_BEEF);
      check("t1_rd", last_rd, 32'd7);

      do_op(2'b00, 3'b100, 32'h0000_0103, 32'd0, 5'd3, 32'h80AA_BBCC, 0, 0, 1'b0);
      check("t2_sbyte_be", last_be, 32'h0000_0008);
      check("t2_sbyte", last_rdata, 32'hFFFF_FF80);
      do_op(2'b00, 3'b011, 32'h0000_0103, 32'd0, 5'd3, 32'h80AA_BBCC, 0, 0, 1'b0);
      check("t2_ubyte", last_rdata, 32'h0000_0080);
      do_op(2'b00, 3'b010, 32'h0000_0102, 32'd0, 5'd3, 32'h80AA_BBCC, 0, 0, 1'b0);
      check("t2_shalf", last_rdata, 32'hFFFF_80AA);

      do_op(2'b01, 3'b010, 32'h0000_0206, 32'h1234_5678, 5'd9, 32'd0, 0, 0, 1'b0);
      check("t3_rwn", last_rwn, 32'd0);
      check("t3_addr", last_addr, 32'h0000_0204);
      check("t3_be", last_be, 32'h0000_000C);
      check("t3_dout", last_dout, 32'h5678_5678);
      check("t3_rdata", last_rdata, 32'd0);
      check("t3_rd", last_rd, 32'd0);

      do_op(2'b00, 3'b000, 32'h0000_0010, 32'd0, 5'd4, 32'h0BAD_F00D, 5, 0, 1'b1);
      do_op(2'b00, 3'b000, 32'h0000_0020, 32'd0, 5'd4, 32'h0, 100, 0, 1'b0);
      check("t4_timeout_err", last_err, 32'd1);

      // Reset in the middle of ACCESS, then a late ACK that must be ignored
      req_valid = 1'b1; req_op = 2'b00; req_size = 3'b000; req_addr = 32'h40; req_rd = 5'd5;
      step();
      req_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_rst_req", {31'd0, dmem_req}, 32'd0);
      check("t5_rst_ready", {31'd0, req_ready}, 32'd1);
      check("t5_rst_resp", {31'd0, resp_valid}, 32'd0);
      dmem_ack = 1'b1; dmem_din = 32'h1111_2222;
      step();
      dmem_ack = 1'b0;
      check("t5_late_ack_resp", {31'd0, resp_valid}, 32'd0);
      check("t5_late_ack_stall", {31'd0, stall}, 32'd0);
      do_op(2'b00, 3'b001, 32'h0000_0302, 32'd0, 5'd12, 32'hCAFE_1234, 1, 3, 1'b0);

      do_op(2'b00, 3'b000, 32'h0000_0101, 32'd0, 5'd6, 32'h7654_3210, 0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
      check("t6_no_bus", last_req, 32'd0);
      check("t6_err", last_err, 32'd1);
      check("t6_rd", last_rd, 32'd6);
`else
      check("t6_addr", last_addr, 32'h0000_0100);
      check("t6_be", last_be, 32'h0000_000F);
      check("t6_err", last_err, 32'd0);
      check("t6_rdata", last_rdata, 32'h7654_3210);
`endif

      // No-op codes and halt must not be accepted
      req_valid = 1'b1; req_op = 2'b10;
      step();
      check("noop10_stall", {31'd0, stall}, 32'd0);
      req_op = 2'b11;
      step();
      check("noop11_stall", {31'd0, stall}, 32'd0);
      req_op = 2'b00; halt = 1'b1;
      step();
      check("halt_idle_stall", {31'd0, stall}, 32'd0);
      req_valid = 1'b0; halt = 1'b0;

      for (int n = 0; n < 60; n++) begin
         int r, lat;
         r   = int'($urandom_range(0, 9));
         lat = (r == 9) ? TMO + 3 : r % 4;
         do_op(2'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
               lat, int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
